mandelbrot_point_dispatcher: RTL
================================

MANDELBROT_POINT_DISPATCHER -- requirements
Module: mandelbrot_point_dispatcher

Interface
REQ-001 SHALL have parameter N_ENGINES, default 2, number of attached mandelbrot_point engines (2..8).
REQ-002 SHALL have parameter ITER_BITS, default 10, width of iteration counts.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 job_req  in  1  requester holds high with stable job_x/job_y until job_ack.
REQ-007 job_ack  out  1  one-cycle pulse: job accepted.
REQ-008 job_x, job_y  in  32 each  signed Q3.29 point coordinates.
REQ-009 max_iterations  in  ITER_BITS  iteration limit 1..1023, static while busy.
REQ-010 res_valid  out  1  result available.
REQ-011 res_ready  in  1  consumer accepts result when high with res_valid.
REQ-012 res_count  out  ITER_BITS  iteration count of oldest unretired job.
REQ-013 res_in_set  out  1  res_count >= max_iterations.
REQ-014 eng_req  out  N_ENGINES  per-engine request, held until eng_ack.
REQ-015 eng_ack  in  N_ENGINES  per-engine acknowledge.
REQ-016 eng_x, eng_y  out  N_ENGINES*32 each  packed per-engine coordinates, engine i at [32i+31:32i].
REQ-017 eng_done  in  N_ENGINES  one-cycle completion pulse per engine.
REQ-018 eng_count  in  N_ENGINES*ITER_BITS  packed iteration_count_out per engine.
REQ-019 busy  out  1  high while any job is outstanding.
REQ-020 outstanding  out  4  number of accepted, unretired jobs.

Function
REQ-021 SHALL dispatch jobs in strict round-robin: job k goes to engine k mod N_ENGINES via dispatch pointer dp.
REQ-022 SHALL retire results in strict round-robin via retire pointer rp, so results leave in acceptance order.
REQ-023 SHALL keep per-engine slot state IDLE, ISSUE, RUN, HOLD.
REQ-024 IDLE->ISSUE when job accepted for that engine: latch job_x/job_y into eng_x/eng_y, assert eng_req.
REQ-025 ISSUE->RUN on eng_ack: deassert eng_req next cycle.
REQ-026 RUN->HOLD on eng_done: capture eng_count slice; an eng_done in any other state SHALL be ignored.
REQ-027 HOLD->IDLE on retire (res_valid && res_ready with rp at that engine).
REQ-028 SHALL accept a job (pulse job_ack) when job_req=1, slot[dp]=IDLE and job_ack was 0 in the previous cycle; dp increments modulo N_ENGINES.
REQ-029 Accept-to-eng_req latency SHALL be 1 cycle; eng_done to res_valid latency SHALL be 1 cycle when that slot is at rp.
REQ-030 res_valid SHALL equal (slot[rp]==HOLD); res_count/res_in_set SHALL be held stable while res_valid && !res_ready.
REQ-031 Slot state SHALL be sampled at cycle start: a slot freed by retire SHALL NOT be dispatched in the same cycle (earliest next cycle).
REQ-032 Simultaneous accept and retire SHALL leave outstanding unchanged; accept-only +1; retire-only -1.
REQ-033 Full (all slots non-IDLE): job_req SHALL wait, job_ack stays 0, no state change.
REQ-034 Empty: busy=0, res_valid=0, outstanding=0.
REQ-035 res_in_set SHALL compare captured count against max_iterations combinationally at output.

Reset
REQ-036 On reset all slots SHALL go IDLE; dp=rp=0; job_ack=0, eng_req=0, res_valid=0, busy=0, outstanding=0, eng_x=eng_y=0, res_count=0.
REQ-037 Reset mid-operation SHALL discard all outstanding jobs; engine eng_done pulses arriving after reset SHALL be ignored (slots IDLE).

Structure
REQ-038 Slot state enum, N_ENGINES maximum and Q3.29 coordinate typedef SHALL live in shared package mandelbrot_pkg.
REQ-039 SHALL contain one sub-module, dispatch_slot, instantiated N_ENGINES times holding one engine's state, coordinates and captured count.
REQ-040 SHALL not instantiate mandelbrot_point; engines are connected at the parent.

Verification
REQ-041 Single job x=0xF0000000, y=0, engine model done after 5 cycles with count 3, max_iterations=100 -> job_ack, eng_req[0] next cycle, res_valid with res_count=3, res_in_set=0.
REQ-042 Four jobs back-to-back, N=2, engine 1 finishes before engine 0 -> results retired in order 0,1,2,3; no job_ack while both slots busy.
REQ-043 Count 100 with max_iterations=100 -> res_in_set=1.
REQ-044 res_ready held 0 for 10 cycles with res_valid=1 -> res_count stable, outstanding=2, third job_req not acked.
REQ-045 Retire and new job_req in same cycle on full pipe -> retire completes, job_ack one cycle later, outstanding stays 2.
REQ-046 reset asserted with 2 outstanding, stale eng_done after -> res_valid=0, busy=0, outstanding=0, no spurious result.

Source files
------------

// File: rtl/mandelbrot_point_dispatcher_pkg.sv
// Shared types for the Mandelbrot point dispatcher: engine limit,
// Q3.29 coordinate type and the per-engine slot state encoding.
package mandelbrot_pkg;

  localparam int MAX_ENGINES = 8;
  localparam int COORD_W     = 32;

  // Signed fixed point: 3 integer bits (incl. sign), 29 fraction bits.
  typedef logic signed [COORD_W-1:0] q3_29_t;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_ISSUE,
    SLOT_RUN,
    SLOT_HOLD
  } slot_state_t;

endpackage

// File: rtl/mandelbrot_point_dispatcher_if.sv
// Job/result handshake bundle between a requester/consumer (master) and
// the dispatcher (slave).
interface mandelbrot_point_dispatcher_if #(
  parameter int ITER_BITS = 10
);
  import mandelbrot_pkg::*;

  logic                 job_req;
  logic                 job_ack;
  q3_29_t               job_x;
  q3_29_t               job_y;
  logic [ITER_BITS-1:0] max_iterations;
  logic                 res_valid;
  logic                 res_ready;
  logic [ITER_BITS-1:0] res_count;
  logic                 res_in_set;

  modport master (
    output job_req, job_x, job_y, max_iterations, res_ready,
    input  job_ack, res_valid, res_count, res_in_set
  );

  modport slave (
    input  job_req, job_x, job_y, max_iterations, res_ready,
    output job_ack, res_valid, res_count, res_in_set
  );

endinterface

// File: rtl/mandelbrot_point_dispatcher_slot.sv
// One engine's bookkeeping: IDLE -> ISSUE -> RUN -> HOLD -> IDLE, with the
// latched job coordinates and the captured iteration count.
module dispatch_slot
  import mandelbrot_pkg::*;
#(
  parameter int ITER_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 accept,
  input  q3_29_t               job_x,
  input  q3_29_t               job_y,
  input  logic                 ack,
  input  logic                 done,
  input  logic [ITER_BITS-1:0] count_in,
  input  logic                 retire,
  output slot_state_t          state,
  output logic                 eng_req,
  output q3_29_t               eng_x,
  output q3_29_t               eng_y,
  output logic [ITER_BITS-1:0] count
);

  slot_state_t next_state;

  // State register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= SLOT_IDLE;
    else       state <= next_state;
  end

  // Next-state decode; a done pulse outside RUN is ignored.
  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    next_state = state;
    case (state)
      SLOT_IDLE:  if (accept) next_state = SLOT_ISSUE;
      SLOT_ISSUE: if (ack)    next_state = SLOT_RUN;
      SLOT_RUN:   if (done)   next_state = SLOT_HOLD;
      SLOT_HOLD:  if (retire) next_state = SLOT_IDLE;
      default:                next_state = SLOT_IDLE;
    endcase
  end

  // Request to the engine is a pure function of state (Moore output).
  always_comb begin
    eng_req = (state == SLOT_ISSUE);
  end

  // Coordinates latch on dispatch; count captures on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_x <= '0;
      eng_y <= '0;
      count <= '0;
    end else begin
      if (accept && state == SLOT_IDLE) begin
        eng_x <= job_x;
        eng_y <= job_y;
      end
      if (done && state == SLOT_RUN) count <= count_in;
    end
  end

endmodule

// File: rtl/mandelbrot_point_dispatcher.sv
// Round-robin dispatcher for N_ENGINES Mandelbrot point engines. Jobs are
// issued to engine dp, results retired from engine rp, so results leave in
// acceptance order.
module mandelbrot_point_dispatcher
  import mandelbrot_pkg::*;
#(
  parameter int N_ENGINES = 2,
  parameter int ITER_BITS = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  mandelbrot_point_dispatcher_if.slave   bus,
  output logic [N_ENGINES-1:0]           eng_req,
  input  logic [N_ENGINES-1:0]           eng_ack,
  output logic [N_ENGINES*32-1:0]        eng_x,
  output logic [N_ENGINES*32-1:0]        eng_y,
  input  logic [N_ENGINES-1:0]           eng_done,
  input  logic [N_ENGINES*ITER_BITS-1:0] eng_count,
  output logic                           busy,
  output logic [3:0]                     outstanding
);

  localparam int PTR_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_ENGINES - 1);

  slot_state_t          slot_state [N_ENGINES];
  logic [ITER_BITS-1:0] slot_count [N_ENGINES];
  logic [PTR_W-1:0]     dp;
  logic [PTR_W-1:0]     rp;
  logic                 ack_q;
  logic                 accept;
  logic                 retire;

  // Accept uses registered slot state, so a slot freed this cycle is not
  // reused until next cycle; ack_q forces a gap after every job_ack.
  always_comb begin
    accept      = bus.job_req && (slot_state[dp] == SLOT_IDLE) && !ack_q;
    bus.job_ack = accept;
  end

  // Result port shows the slot at the retire pointer.
  always_comb begin
    bus.res_valid  = (slot_state[rp] == SLOT_HOLD);
    bus.res_count  = bus.res_valid ? slot_count[rp] : '0;
    bus.res_in_set = bus.res_valid && (bus.res_count >= bus.max_iterations);
    retire         = bus.res_valid && bus.res_ready;
  end

  // Pointers, ack history and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp          <= '0;
      rp          <= '0;
      ack_q       <= 1'b0;
      outstanding <= '0;
    end else begin
      ack_q <= accept;
      if (accept) dp <= (dp == LAST) ? '0 : dp + PTR_W'(1);
      if (retire) rp <= (rp == LAST) ? '0 : rp + PTR_W'(1);
      case ({accept, retire})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Busy whenever any accepted job has not yet been retired.
  always_comb begin
    busy = (outstanding != 4'd0);
  end

  for (genvar i = 0; i < N_ENGINES; i++) begin : g_slot
    dispatch_slot #(.ITER_BITS(ITER_BITS)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .accept   (accept && (dp == PTR_W'(i))),
      .job_x    (bus.job_x),
      .job_y    (bus.job_y),
      .ack      (eng_ack[i]),
      .done     (eng_done[i]),
      .count_in (eng_count[i*ITER_BITS +: ITER_BITS]),
      .retire   (retire && (rp == PTR_W'(i))),
      .state    (slot_state[i]),
      .eng_req  (eng_req[i]),
      .eng_x    (eng_x[i*32 +: 32]),
      .eng_y    (eng_y[i*32 +: 32]),
      .count    (slot_count[i])
    );
  end

endmodule
